// File: rtl/sint32_add_sequencer.sv
// Two-pass signed add/subtract: one HALF_W-bit adder slice is reused for the
// low half and then the high half (with the registered carry), so a
// 2*HALF_W-bit operation costs four cycles (IDLE, LO, HI, DONE) instead of a
// full-width adder.
//
// Optional build macro: SINT_ADD_SATURATE_EN clamps an overflowing result to
// the most positive / most negative value instead of wrapping.
module sint32_add_sequencer #(
  parameter int unsigned HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] op_a,
  input  logic [2*HALF_W-1:0] op_b,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] result,
  output logic                cout,
  output logic                ovf
);

  localparam int unsigned W = 2 * HALF_W;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operands as seen by the adder: B is pre-inverted for subtraction.
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              cin_q, cin_d;

  // Low-half partial result and carry into the high pass.
  logic [HALF_W-1:0] res_lo_q, res_lo_d;
  logic              c_lo_q, c_lo_d;

  // Architectural outputs; only written in HI, held otherwise.
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Shared adder slice.
  logic [HALF_W-1:0] slice_a, slice_b;
  logic              slice_c;
  logic [HALF_W:0]   slice_sum;
  logic              ovf_calc;
  logic [W-1:0]      sat_val;

  // Operand mux for the shared slice: high halves plus carry in HI, low halves plus cin otherwise.
  always_comb begin
    slice_a = a_q[HALF_W-1:0];
    slice_b = b_q[HALF_W-1:0];
    slice_c = cin_q;
    if (state_q == StHi) begin
      slice_a = a_q[W-1:HALF_W];
      slice_b = b_q[W-1:HALF_W];
      slice_c = c_lo_q;
    end
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{HALF_W{1'b0}}, slice_c};
    // Signed overflow: like-signed operands producing a result of the other sign.
    ovf_calc  = (a_q[W-1] == b_q[W-1]) & (slice_sum[HALF_W-1] != a_q[W-1]);
    sat_val   = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    res_lo_d = res_lo_q;
    c_lo_d   = c_lo_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          cin_d   = op_sub;
          state_d = StLo;
        end
      end
      StLo: begin
        res_lo_d = slice_sum[HALF_W-1:0];
        c_lo_d   = slice_sum[HALF_W];
        state_d  = StHi;
      end
      StHi: begin
        result_d = {slice_sum[HALF_W-1:0], res_lo_q};
        cout_d   = slice_sum[HALF_W];
        ovf_d    = ovf_calc;
`ifdef SINT_ADD_SATURATE_EN
        if (ovf_calc) begin
          result_d = sat_val;
        end
`endif
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      res_lo_q <= '0;
      c_lo_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      res_lo_q <= res_lo_d;
      c_lo_q   <= c_lo_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

`ifndef SINT_ADD_SATURATE_EN
  // Saturation value is only consumed when clamping is built in.
  logic unused_sat;
  assign unused_sat = ^sat_val;
`endif

  // Handshakes decode straight from the state register.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sint32_add_sequencer.sv
// Randomized self-checking bench for sint32_add_sequencer against a signed
// arithmetic reference model.
module tb_sint32_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

  sint32_add_sequencer #(
    .HALF_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_sub   (op_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact signed result in 64-bit arithmetic, then truncate / clamp.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output logic c, output logic o);
    longint          sa, sb, exact;
    longint unsigned ua, ub;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    exact = sub ? (sa - sb) : (sa + sb);
    o     = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    r     = exact[31:0];
    // Carry out: add overflows 2^32; subtract has no borrow when A >= B unsigned.
    c     = sub ? (ua >= ub) : (((ua + ub) >> 32) != 0);
`ifdef SINT_ADD_SATURATE_EN
    if (o) r = (exact < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One full transaction: accept, latency, result, backpressure hold, release.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input int hold);
    logic [31:0] er;
    logic        ec, eo;
    model(a, b, sub, er, ec, eo);
    check_eq("idle_ready", 64'(in_ready), 64'(1));
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    op_sub   = 1'($urandom_range(0, 1));
    check_eq("lo_ready", 64'(in_ready), 64'(0));
    check_eq("lo_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check_eq("hi_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check_eq("done_valid", 64'(out_valid), 64'(1));
    check_eq("result", 64'(result), 64'(er));
    check_eq("cout", 64'(cout), 64'(ec));
    check_eq("ovf", 64'(ovf), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a     = $urandom;
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid), 64'(1));
      check_eq("hold_ready", 64'(in_ready), 64'(0));
      check_eq("hold_result", 64'(result), 64'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("rel_valid", 64'(out_valid), 64'(0));
    check_eq("rel_ready", 64'(in_ready), 64'(1));
    check_eq("rel_result", 64'(result), 64'(er));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_ready", 64'(in_ready), 64'(1));
    check_eq("rst_valid", 64'(out_valid), 64'(0));
    check_eq("rst_result", 64'(result), 64'(0));
    check_eq("rst_cout", 64'(cout), 64'(0));
    check_eq("rst_ovf", 64'(ovf), 64'(0));

    // Directed corner cases.
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5);

    // Reset while in HI: nothing partial may leak out.
    op_a     = 32'h1234_5678;
    op_b     = 32'h1111_1111;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_valid", 64'(out_valid), 64'(0));
    check_eq("abort_result", 64'(result), 64'(0));
    check_eq("abort_ready", 64'(in_ready), 64'(1));
    check_eq("abort_ovf", 64'(ovf), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("abort_stay", 64'(out_valid), 64'(0));
    end
    run_op(32'hFFFF_0000, 32'h0001_0001, 1'b1, 2);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 60; n++) begin
      run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
